// File: rtl/bcd_arb_pkg.sv
// Shared types and constants for the two-requester BCD conversion arbiter.
package bcd_arb_pkg;

  localparam int unsigned NumReq = 2;
  localparam int unsigned CntW   = 5;

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StDeliver} state_e;

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a contested grant goes to the requester not served last.
module rr_arbiter2
  import bcd_arb_pkg::*;
(
  input  logic [NumReq-1:0] req_i,
  input  logic              last_i,
  output logic              grant_o,
  output logic              grant_valid_o
);

  always_comb begin
    grant_valid_o = |req_i;
    if (req_i[0] && req_i[1]) begin
      grant_o = ~last_i;
    end else begin
      grant_o = req_i[1];
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Arbitrates two requesters onto one serial BCD-to-binary engine.
// Define BCD_ARB_VALIDATE_EN to reject operands with a digit above 9.
module bcd_conv_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NumReq-1:0] req,
  input  logic [7:0]        bcd0,
  input  logic [7:0]        bcd1,
  output logic [NumReq-1:0] done,
  output logic [NumReq-1:0] err,
  output logic [6:0]        result0,
  output logic [6:0]        result1,
  output logic              conv_load,
  output logic [7:0]        conv_bcd,
  input  logic              conv_ready,
  input  logic              conv_done_tick,
  input  logic [7:0]        conv_bin
);

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic [7:0]        operand_q, operand_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [NumReq-1:0] err_q, err_d;
  logic [6:0]        result0_q, result0_d;
  logic [6:0]        result1_q, result1_d;
  logic              arb_grant, arb_valid;
  logic [7:0]        sel_bcd;
  logic              unused_bin;

  assign unused_bin = conv_bin[7];

  rr_arbiter2 u_rr (
    .req_i         (req),
    .last_i        (last_q),
    .grant_o       (arb_grant),
    .grant_valid_o (arb_valid)
  );

  assign sel_bcd  = arb_grant ? bcd1 : bcd0;
  assign err      = err_q;
  assign result0  = result0_q;
  assign result1  = result1_q;
  assign conv_bcd = operand_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    operand_d = operand_q;
    cnt_d     = cnt_q;
    err_d     = '0;
    result0_d = result0_q;
    result1_d = result1_q;
    conv_load = 1'b0;
    done      = '0;
    case (state_q)
      StIdle: begin
        if (arb_valid) begin
          grant_d   = arb_grant;
          operand_d = sel_bcd;
          cnt_d     = '0;
`ifdef BCD_ARB_VALIDATE_EN
          if (!bcd_ok(sel_bcd)) begin
            err_d[arb_grant] = 1'b1;
            last_d           = arb_grant;
          end else begin
            state_d = StLoad;
          end
`else
          state_d = StLoad;
`endif
        end
      end
      StLoad: begin
        if (conv_ready) begin
          conv_load = 1'b1;
          cnt_d     = '0;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (conv_done_tick) begin
          if (grant_q) result1_d = conv_bin[6:0];
          else         result0_d = conv_bin[6:0];
          state_d = StDeliver;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          // Abort: the result register keeps its previous value.
          err_d[grant_q] = 1'b1;
          last_d         = grant_q;
          state_d        = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDeliver: begin
        done[grant_q] = 1'b1;
        last_d        = grant_q;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      operand_q <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
      result0_q <= '0;
      result1_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      operand_q <= operand_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      result0_q <= result0_d;
      result1_q <= result1_d;
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter; inputs change and outputs are checked on falling edges.
module tb_bcd_conv_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [7:0] bcd0, bcd1;
  logic [1:0] done, err;
  logic [6:0] result0, result1;
  logic       conv_load;
  logic [7:0] conv_bcd;
  logic       conv_ready, conv_done_tick;
  logic [7:0] conv_bin;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  bcd_conv_arbiter #(.TIMEOUT(15)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .bcd0           (bcd0),
    .bcd1           (bcd1),
    .done           (done),
    .err            (err),
    .result0        (result0),
    .result1        (result1),
    .conv_load      (conv_load),
    .conv_bcd       (conv_bcd),
    .conv_ready     (conv_ready),
    .conv_done_tick (conv_done_tick),
    .conv_bin       (conv_bin)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Full transaction on requester r with the engine answering after dly extra WAIT cycles.
  task automatic run_xact(input bit r, input logic [7:0] bcd, input logic [7:0] bin,
                          input int dly, input logic [6:0] exp);
    logic [1:0] oh;
    oh  = r ? 2'b10 : 2'b01;
    req = oh;
    if (r) bcd1 = bcd;
    else   bcd0 = bcd;
    nxt();
    chk("x_load", 32'(conv_load), 32'(1));
    chk("x_bcd", 32'(conv_bcd), 32'(bcd));
    nxt();
    chk("x_load_once", 32'(conv_load), 32'(0));
    nxt(dly);
    chk("x_no_early_done", 32'(done), 32'(0));
    conv_done_tick = 1'b1;
    conv_bin       = bin;
    nxt();
    chk("x_done", 32'(done), 32'(oh));
    chk("x_err", 32'(err), 32'(0));
    chk("x_result", 32'(r ? result1 : result0), 32'(exp));
    conv_done_tick = 1'b0;
    req            = 2'b00;
    nxt();
    chk("x_done_one_cycle", 32'(done), 32'(0));
  endtask

  initial begin
    reset = 1'b1; req = 2'b00; bcd0 = '0; bcd1 = '0;
    conv_ready = 1'b1; conv_done_tick = 1'b0; conv_bin = '0;
    nxt(2);
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_load", 32'(conv_load), 32'(0));
    chk("rst_bcd", 32'(conv_bcd), 32'(0));
    chk("rst_res0", 32'(result0), 32'(0));
    chk("rst_res1", 32'(result1), 32'(0));
    reset = 1'b0;

    // Single request, engine answers on the 8th WAIT cycle.
    run_xact(1'b0, 8'h42, 8'd42, 7, 7'h2A);

    // Simultaneous requests after reset: 0 first, then 1 while 0 keeps req high.
    reset = 1'b1;
    nxt();
    chk("rst2_res0", 32'(result0), 32'(0));
    chk("rst2_load", 32'(conv_load), 32'(0));
    reset = 1'b0;
    req = 2'b11; bcd0 = 8'h07; bcd1 = 8'h99;
    nxt();
    chk("both_load0", 32'(conv_load), 32'(1));
    chk("both_bcd0", 32'(conv_bcd), 32'h07);
    nxt();
    conv_done_tick = 1'b1; conv_bin = 8'd7;
    nxt();
    chk("both_done0", 32'(done), 32'h1);
    chk("both_res0", 32'(result0), 32'h07);
    conv_done_tick = 1'b0;
    nxt();
    chk("both_gap_done", 32'(done), 32'(0));
    chk("both_gap_load", 32'(conv_load), 32'(0));
    nxt();
    chk("both_load1", 32'(conv_load), 32'(1));
    chk("both_bcd1", 32'(conv_bcd), 32'h99);
    nxt();
    conv_done_tick = 1'b1; conv_bin = 8'd99;
    nxt();
    chk("both_done1", 32'(done), 32'h2);
    chk("both_res1", 32'(result1), 32'h63);
    chk("both_res0_kept", 32'(result0), 32'h07);
    conv_done_tick = 1'b0; req = 2'b00;
    nxt();
    chk("both_idle_done", 32'(done), 32'(0));

    // Engine tick while IDLE must not touch results.
    conv_done_tick = 1'b1; conv_bin = 8'h55;
    nxt();
    chk("stray_done", 32'(done), 32'(0));
    chk("stray_res0", 32'(result0), 32'h07);
    chk("stray_res1", 32'(result1), 32'h63);
    conv_done_tick = 1'b0;

    // Backpressure: engine busy for 5 cycles after the grant.
    conv_ready = 1'b0; req = 2'b01; bcd0 = 8'h15;
    for (int i = 0; i < 5; i++) begin
      nxt();
      chk("bp_held", 32'(conv_load), 32'(0));
    end
    conv_ready = 1'b1;
    #1;
    chk("bp_load", 32'(conv_load), 32'(1));
    chk("bp_bcd", 32'(conv_bcd), 32'h15);
    nxt();
    chk("bp_load_once", 32'(conv_load), 32'(0));
    conv_done_tick = 1'b1; conv_bin = 8'd15;
    nxt();
    chk("bp_done", 32'(done), 32'h1);
    chk("bp_res0", 32'(result0), 32'h0F);
    conv_done_tick = 1'b0; req = 2'b00;
    nxt();

    // Timeout: no engine tick for 15 WAIT cycles.
    req = 2'b10; bcd1 = 8'h31;
    nxt();
    chk("to_load", 32'(conv_load), 32'(1));
    for (int k = 0; k < 15; k++) begin
      nxt();
      chk("to_no_err", 32'(err), 32'(0));
    end
    nxt();
    chk("to_err", 32'(err), 32'h2);
    chk("to_no_done", 32'(done), 32'(0));
    chk("to_res1_kept", 32'(result1), 32'h63);
    req = 2'b00;
    nxt();
    chk("to_err_one_cycle", 32'(err), 32'(0));
    run_xact(1'b0, 8'h58, 8'd58, 0, 7'h3A);

    // Operand with an illegal tens digit.
`ifdef BCD_ARB_VALIDATE_EN
    req = 2'b10; bcd1 = 8'hA5;
    nxt();
    chk("val_err", 32'(err), 32'h2);
    chk("val_no_load", 32'(conv_load), 32'(0));
    req = 2'b00;
    nxt();
    chk("val_err_one_cycle", 32'(err), 32'(0));
    chk("val_still_no_load", 32'(conv_load), 32'(0));
`else
    run_xact(1'b1, 8'hA5, 8'h69, 0, 7'h69);
`endif

    // Reset during WAIT: prior grant went to 0, so only reset can make 0 win next.
    run_xact(1'b0, 8'h20, 8'd20, 0, 7'h14);
    req = 2'b10; bcd1 = 8'h77;
    nxt();
    chk("rw_load", 32'(conv_load), 32'(1));
    nxt(2);
    reset = 1'b1; conv_done_tick = 1'b1; conv_bin = 8'd77;
    nxt();
    chk("rw_done", 32'(done), 32'(0));
    chk("rw_err", 32'(err), 32'(0));
    chk("rw_load0", 32'(conv_load), 32'(0));
    chk("rw_bcd0", 32'(conv_bcd), 32'(0));
    chk("rw_res0", 32'(result0), 32'(0));
    chk("rw_res1", 32'(result1), 32'(0));
    reset = 1'b0; conv_done_tick = 1'b0; req = 2'b00;
    nxt();
    chk("rw_no_late_done", 32'(done), 32'(0));
    chk("rw_no_late_err", 32'(err), 32'(0));
    req = 2'b11; bcd0 = 8'h33; bcd1 = 8'h44;
    nxt();
    chk("rw_regrant_load", 32'(conv_load), 32'(1));
    chk("rw_regrant_bcd0", 32'(conv_bcd), 32'h33);
    nxt();
    conv_done_tick = 1'b1; conv_bin = 8'd33;
    nxt();
    chk("rw_done0", 32'(done), 32'h1);
    chk("rw_res0_33", 32'(result0), 32'h21);
    conv_done_tick = 1'b0; req = 2'b00;
    nxt();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
